// File: rtl/ahb3lite_arbiter.sv
// ahb3lite_arbiter: round-robin arbiter for the shared AHB3-Lite master port.
// Grants one requester at a time and only hands over between transfers,
// never inside a fixed-length burst or a locked sequence. Drives the
// address-phase and data-phase master-select indices for the external muxes.
module ahb3lite_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [3:0]             HBURST,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MW-1:0]          HMASTER,
   output logic [MW-1:0]          HMASTER_D,
   output logic                   HMASTLOCK
);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [3:0] BU_SINGLE = 4'd0;
   localparam logic [3:0] BU_INCR   = 4'd1;
   localparam logic [3:0] BU_WRAP4  = 4'd2;
   localparam logic [3:0] BU_INCR4  = 4'd3;
   localparam logic [3:0] BU_WRAP8  = 4'd4;
   localparam logic [3:0] BU_INCR8  = 4'd5;
   localparam logic [3:0] BU_WRAP16 = 4'd6;
   localparam logic [3:0] BU_INCR16 = 4'd7;

   typedef enum logic [1:0] {PARK, OWN, BURST, LOCKED} state_t;

   // Remaining beats after the NONSEQ of a fixed-length burst; 0 for open-ended ones.
   function automatic logic [3:0] burst_beats(input logic [3:0] burst);
      case (burst)
         BU_WRAP4,  BU_INCR4:  burst_beats = 4'd3;
         BU_WRAP8,  BU_INCR8:  burst_beats = 4'd7;
         BU_WRAP16, BU_INCR16: burst_beats = 4'd15;
         default:              burst_beats = 4'd0;
      endcase
   endfunction

   state_t                 state;
   logic [MW-1:0]          last;
   logic [3:0]             beats;
   logic [MW-1:0]          gidx;
   logic [MW-1:0]          cand;
   logic [MW-1:0]          idx;
   logic                   found;
   logic                   any_req;
   logic [NUM_MASTERS-1:0] cand_onehot;
   logic                   owner_req;
   logic                   owner_lock;
   logic                   others_req;
   logic                   is_idle;
   logic                   is_nonseq;
   logic                   is_seq;
   logic                   open_beat;
   logic                   start_burst;
   logic                   owner_active;
   logic                   own_handover;
   logic                   burst_done;
   logic                   handover;

   // Encode the one-hot grant into the owner index.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (HGRANT[i]) gidx = gidx | MW'(i);
   end

   // Round-robin scan starting just after the last winner; park on master 0.
   always_comb begin
      cand    = '0;
      idx     = '0;
      found   = 1'b0;
      any_req = |HBUSREQ;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = MW'((int'(last) + i) % NUM_MASTERS);
         if (!found && HBUSREQ[idx]) begin
            cand  = idx;
            found = 1'b1;
         end
      end
      cand_onehot = NUM_MASTERS'(1) << cand;
   end

   // Handover qualification. HTRANS belongs to the address-phase owner, so the
   // granted master's traffic is only judged once it actually owns the address bus.
   always_comb begin
      owner_req    = HBUSREQ[gidx];
      owner_lock   = HLOCK[gidx];
      others_req   = |(HBUSREQ & ~HGRANT);
      is_idle      = (HTRANS == TR_IDLE);
      is_nonseq    = (HTRANS == TR_NONSEQ);
      is_seq       = (HTRANS == TR_SEQ);
      open_beat    = (is_nonseq || is_seq) && (HBURST == BU_SINGLE || HBURST == BU_INCR);
      start_burst  = HREADY && is_nonseq && (burst_beats(HBURST) != 4'd0);
      owner_active = (HMASTER == gidx);
      own_handover = HREADY && (beats == 4'd0) && owner_active && !start_burst && !owner_lock &&
                     (!owner_req || is_idle || (others_req && open_beat));
      burst_done   = HREADY && ((beats == 4'd0) || is_idle);
      handover     = ((state == PARK)  && HREADY && any_req) ||
                     ((state == OWN)   && own_handover) ||
                     ((state == BURST) && burst_done);
   end

   // Beat counter tracking how much of a fixed-length burst is still owed.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         beats <= 4'd0;
      end else if (HREADY) begin
         case (HTRANS)
            TR_NONSEQ: beats <= burst_beats(HBURST);
            TR_SEQ:    if (beats != 4'd0) beats <= beats - 4'd1;
            TR_BUSY:   beats <= beats;
            default:   beats <= 4'd0;
         endcase
      end
   end

   // Arbitration FSM owning the grant and the round-robin pointer.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state  <= PARK;
         HGRANT <= NUM_MASTERS'(1);
         last   <= '0;
      end else if (handover) begin
         if (any_req) begin
            HGRANT <= cand_onehot;
            last   <= cand;
            state  <= OWN;
         end else begin
            HGRANT <= NUM_MASTERS'(1);
            state  <= PARK;
         end
      end else begin
         case (state)
            OWN: begin
               if (owner_lock)       state <= LOCKED;
               else if (start_burst) state <= BURST;
            end
            LOCKED: begin
               if (!owner_lock && HREADY && (is_nonseq || is_seq)) state <= OWN;
            end
            default: ;
         endcase
      end
   end

   // Address/data-phase owner pipeline, advancing only on ready cycles.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         HMASTER   <= '0;
         HMASTER_D <= '0;
         HMASTLOCK <= 1'b0;
      end else if (HREADY) begin
         HMASTER   <= gidx;
         HMASTER_D <= HMASTER;
         HMASTLOCK <= owner_lock;
      end
   end

endmodule

// File: tb/tb_ahb3lite_arbiter.sv
// tb_ahb3lite_arbiter: directed checks of the round-robin AHB3-Lite arbiter.
module tb_ahb3lite_arbiter;

   localparam logic [1:0] I   = 2'b00;
   localparam logic [1:0] NS  = 2'b10;
   localparam logic [1:0] SQ  = 2'b11;
   localparam logic [3:0] SGL = 4'd0;
   localparam logic [3:0] INC = 4'd1;
   localparam logic [3:0] W4  = 4'd2;
   localparam logic [3:0] I8  = 4'd5;
   localparam logic [3:0] I16 = 4'd7;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic [3:0] HBUSREQ;
   logic [3:0] HLOCK;
   logic [1:0] HTRANS;
   logic [3:0] HBURST;
   logic       HREADY;
   logic [3:0] HGRANT;
   logic [1:0] HMASTER;
   logic [1:0] HMASTER_D;
   logic       HMASTLOCK;

   int n_run  = 0;
   int n_fail = 0;

   ahb3lite_arbiter #(.NUM_MASTERS(4)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HBUSREQ   (HBUSREQ),
      .HLOCK     (HLOCK),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HREADY    (HREADY),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER),
      .HMASTER_D (HMASTER_D),
      .HMASTLOCK (HMASTLOCK)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] ehm,
                          input logic [1:0] ehmd, input logic elk);
      chk({tag, ".grant"}, 32'(HGRANT), 32'(eg));
      chk({tag, ".hmaster"}, 32'(HMASTER), 32'(ehm));
      chk({tag, ".hmaster_d"}, 32'(HMASTER_D), 32'(ehmd));
      chk({tag, ".mastlock"}, 32'(HMASTLOCK), 32'(elk));
   endtask

   // One bus cycle: apply inputs, clock once, check state after the edge.
   task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] tr, input logic [3:0] bu, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] ehm, input logic [1:0] ehmd,
                       input logic elk);
      HBUSREQ = req;
      HLOCK   = lock;
      HTRANS  = tr;
      HBURST  = bu;
      HREADY  = rdy;
      @(posedge HCLK);
      #1;
      chk_all(tag, eg, ehm, ehmd, elk);
   endtask

   task automatic do_reset();
      HRESET  = 1'b1;
      HBUSREQ = '0;
      HLOCK   = '0;
      HTRANS  = I;
      HBURST  = SGL;
      HREADY  = 1'b1;
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
   endtask

   initial begin
      // Reset state and idle parking
      do_reset();
      chk_all("rst", 4'b0001, 2'd0, 2'd0, 1'b0);
      for (int k = 0; k < 10; k++)
         step($sformatf("park%0d", k), 4'b0000, 4'b0000, I, SGL, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

      // Round robin over M1..M3 doing single transfers
      do_reset();
      step("rr.c0", 4'b1110, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step("rr.c1", 4'b1110, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
      step("rr.c2", 4'b1110, 4'b0000, NS, SGL, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0);
      step("rr.c3", 4'b1110, 4'b0000, I,  SGL, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
      step("rr.c4", 4'b1110, 4'b0000, NS, SGL, 1'b1, 4'b1000, 2'd2, 2'd2, 1'b0);
      step("rr.c5", 4'b1110, 4'b0000, I,  SGL, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b0);
      step("rr.c6", 4'b1110, 4'b0000, NS, SGL, 1'b1, 4'b0010, 2'd3, 2'd3, 1'b0);
      step("rr.c7", 4'b1110, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b0);

      // M2 INCR8 with wait states while M0 waits
      do_reset();
      step("b8.c0", 4'b0100, 4'b0000, I,  SGL, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
      step("b8.c1", 4'b0100, 4'b0000, I,  SGL, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0);
      step("b8.c2", 4'b0101, 4'b0000, NS, I8,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      for (int k = 0; k < 3; k++)
         step($sformatf("b8.seq%0d", k), 4'b0101, 4'b0000, SQ, I8, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      for (int k = 0; k < 3; k++)
         step($sformatf("b8.wait%0d", k), 4'b0101, 4'b0000, SQ, I8, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
      for (int k = 0; k < 4; k++)
         step($sformatf("b8.tail%0d", k), 4'b0101, 4'b0000, SQ, I8, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      step("b8.ho",  4'b0101, 4'b0000, I, SGL, 1'b1, 4'b0001, 2'd2, 2'd2, 1'b0);
      step("b8.own", 4'b0101, 4'b0000, I, SGL, 1'b1, 4'b0001, 2'd0, 2'd2, 1'b0);

      // M1 INCR16 terminated early by IDLE, M3 waiting
      do_reset();
      step("b16.c0", 4'b0010, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step("b16.c1", 4'b0010, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
      step("b16.c2", 4'b1010, 4'b0000, NS, I16, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      for (int k = 0; k < 4; k++)
         step($sformatf("b16.seq%0d", k), 4'b1010, 4'b0000, SQ, I16, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      step("b16.idle", 4'b1010, 4'b0000, I,  SGL, 1'b1, 4'b1000, 2'd1, 2'd1, 1'b0);
      step("b16.m3a",  4'b1010, 4'b0000, I,  SGL, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);
      step("b16.m3b",  4'b1010, 4'b0000, NS, SGL, 1'b1, 4'b0010, 2'd3, 2'd3, 1'b0);

      // Locked sequence by M0 while M1 requests
      do_reset();
      step("lk.c0", 4'b0001, 4'b0001, I,  SGL, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1);
      step("lk.c1", 4'b0011, 4'b0001, NS, INC, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1);
      step("lk.c2", 4'b0011, 4'b0001, SQ, INC, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1);
      step("lk.c3", 4'b0011, 4'b0001, SQ, INC, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1);
      step("lk.rel", 4'b0011, 4'b0000, SQ, INC, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
      step("lk.ho",  4'b0011, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step("lk.m1",  4'b0011, 4'b0000, I,  SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);

      // Asynchronous reset during beat 3 of a locked WRAP4
      do_reset();
      step("ar.c0", 4'b0100, 4'b0100, I,  SGL, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
      step("ar.c1", 4'b0100, 4'b0100, I,  SGL, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b1);
      step("ar.c2", 4'b0100, 4'b0100, NS, W4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
      step("ar.c3", 4'b0100, 4'b0100, SQ, W4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
      HTRANS = SQ;
      #2;
      HRESET = 1'b1;
      #1;
      chk_all("ar.async", 4'b0001, 2'd0, 2'd0, 1'b0);
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      step("ar.p0", 4'b0010, 4'b0000, I, SGL, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step("ar.p1", 4'b0010, 4'b0000, I, SGL, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb3lite_arbiter.md
# ahb3lite_arbiter

Round-robin bus arbiter for the shared AHB3-Lite master port. It sits between up to `NUM_MASTERS` requesting nodes and the single address/data path into the slave decoder. It grants ownership one requester at a time and hands over only at legal points: never inside a fixed-length burst or a locked sequence. It drives the master-select indices that steer the external address and write-data multiplexers.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesters, 2..16.
- `MW`, default `$clog2(NUM_MASTERS)`: master index width.

Ports:
- `HCLK` in 1: the block's single clock.
- `HRESET` in 1: asynchronous, active-high reset.
- `HBUSREQ` in `NUM_MASTERS`: per-master bus request, level.
- `HLOCK` in `NUM_MASTERS`: per-master locked-sequence request.
- `HTRANS` in 2: muxed HTRANS of the current address-phase owner (`ahb3lite_pkg::HTRANS_state`).
- `HBURST` in 4: muxed HBURST of the owner (`ahb3lite_pkg::HBURST_Type`).
- `HREADY` in 1: bus ready; transfer accepted when 1.
- `HGRANT` out `NUM_MASTERS`: one-hot grant, registered.
- `HMASTER` out `MW`: address-phase owner index.
- `HMASTER_D` out `MW`: data-phase owner index (write-data mux select).
- `HMASTLOCK` out 1: current address phase is locked.

## Operation
- Reset values:
  - `HGRANT` = 1 (master 0 parked).
  - `HMASTER` = 0, `HMASTER_D` = 0, `HMASTLOCK` = 0.
  - Round-robin pointer `last` = 0.
  - Beat counter `beats` = 0.
  - State = PARK.
- Accepted beat: any cycle with `HREADY`=1 and `HTRANS` ∈ {NONSEQ, SEQ}.
- Beat counter, updated only when `HREADY`=1:
  - NONSEQ with WRAP4/INCR4 loads 3; WRAP8/INCR8 loads 7; WRAP16/INCR16 loads 15.
  - NONSEQ with SINGLE or INCR loads 0.
  - SEQ decrements `beats` when nonzero.
  - BUSY holds `beats`.
  - IDLE clears `beats` to 0 (early termination).
- Candidate selection: first asserted `HBUSREQ[i]` scanning `last+1`, `last+2`, … modulo `NUM_MASTERS`. If no request is asserted, the candidate is master 0 (park).
- States:
  - PARK: no requests; master 0 granted and expected to drive IDLE.
    - Any `HBUSREQ` → OWN, with the grant loaded from the candidate.
  - OWN: owner is doing SINGLE, INCR, or IDLE transfers.
    - On a handover point → re-arbitrate.
    - Accepted NONSEQ that loads `beats`>0 → BURST.
    - `HLOCK[owner]`=1 → LOCKED.
  - BURST: fixed-length burst in flight; grant frozen.
    - When `beats` reaches 0 with `HREADY`=1, or owner drives IDLE → OWN, and this is a handover point.
  - LOCKED: grant frozen while `HLOCK[owner]`=1.
    - On `HLOCK[owner]` falling, one more accepted beat → OWN.
- Handover point: `HREADY`=1, `beats`=0, state not LOCKED, and one of:
  - owner's `HBUSREQ` is low;
  - owner drives IDLE;
  - another master is requesting and the owner's current beat is SINGLE or an INCR beat.
- At a handover point:
  - `HGRANT` <= one-hot(candidate).
  - `last` <= candidate, when the candidate is a real requester.
  - No requests → PARK.
- The owner retains the grant when it is the only requester. No idle cycle is inserted.
- Simultaneous `HLOCK` and competing request: the lock wins. Lock is sampled with `HBUSREQ` at the handover point.

## Timing
- Grant latency: request asserted in cycle n → `HGRANT` rises at edge n+1, provided cycle n is a handover point.
- `HMASTER` <= index(`HGRANT`) on each edge with `HREADY`=1, so address ownership follows grant by one ready cycle.
- `HMASTER_D` <= `HMASTER` on each edge with `HREADY`=1. This gives one-stage pipeline alignment with the data phase.
- `HMASTLOCK` <= `HLOCK[index(HGRANT)]` on edges with `HREADY`=1.
- `HREADY`=0 freezes `HMASTER`, `HMASTER_D`, `HMASTLOCK`, and `beats`. `HGRANT` may still change only if the state permits a handover point, which requires `HREADY`=1, so it is effectively frozen too.
- Reset assertion mid-burst:
  - All outputs return to their reset values asynchronously.
  - The burst is abandoned; no pending grant survives.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then no requests for 10 cycles → `HGRANT`=4'b0001, `HMASTER`=0, `HMASTLOCK`=0 throughout.
- M1, M2, M3 request continuously, each doing SINGLE NONSEQ beats with `HREADY`=1 → grant order M1, M2, M3, M1, one transfer each. `HMASTER_D` lags `HMASTER` by one cycle.
- M2 starts INCR8 while M0 requests:
  - no grant change across 8 beats, even with `HREADY` low for 3 cycles mid-burst;
  - `HGRANT` moves to M0 at the edge after the 8th beat is accepted.
- M1 issues INCR16 and drives IDLE after 5 beats → `beats` cleared; grant moves to the waiting M3 on the next edge.
- M0 asserts `HLOCK` plus `HBUSREQ` with M1 requesting:
  - `HMASTLOCK`=1 and grant held for all locked beats;
  - M1 is granted one edge after the first accepted beat following `HLOCK` deassertion.
- Assert `HRESET` during beat 3 of a WRAP4 → outputs immediately return to their reset values. After release, the first request is serviced from PARK.
